// File: rtl/mac_acc_pkg.sv
// Shared types and arithmetic helpers for the MAC result accumulator.
// The saturating path is selected by MAC_ACC_SATURATE_EN in the top level.
package mac_acc_pkg;

  localparam int FIFO_DEPTH = 2;
  localparam int ACC_W_MAX  = 64;

  typedef enum logic {IDLE, ACCUM} state_t;

  // Accumulator values are held sign-extended to ACC_W_MAX; ACC_WIDTH must stay <= 63
  typedef logic signed [ACC_W_MAX-1:0] acc_t;

  typedef struct packed {
    acc_t sum;
    logic sat;
  } acc_entry_t;

  function automatic acc_t sext(input acc_t v, input int w);
    acc_t t;
    t = v <<< (ACC_W_MAX - w);
    return t >>> (ACC_W_MAX - w);
  endfunction

  function automatic acc_t wrap_add(input acc_t a, input acc_t b, input int w);
    return sext(a + b, w);
  endfunction

  function automatic acc_entry_t sat_add(input acc_t a, input acc_t b, input int w);
    acc_entry_t r;
    acc_t       s;
    acc_t       hi;
    acc_t       lo;
    hi    = (acc_t'(1) <<< (w - 1)) - acc_t'(1);
    lo    = ~hi;
    s     = a + b;
    r.sat = 1'b0;
    if (s > hi) begin
      s     = hi;
      r.sat = 1'b1;
    end else if (s < lo) begin
      s     = lo;
      r.sat = 1'b1;
    end
    r.sum = s;
    return r;
  endfunction

endpackage

// File: rtl/mac_result_accumulator_if.sv
// Input sample stream and output frame-sum handshake of the MAC result accumulator.
interface mac_result_accumulator_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 48
);
  logic                         in_valid;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [ACC_WIDTH-1:0]  out_sum;
  logic                         out_sat;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_sum, out_sat
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_sum, out_sat
  );
endinterface

// File: rtl/mac_acc_out_fifo.sv
// Two-entry valid/ready output buffer; a push into a full buffer succeeds when a pop happens in the same cycle.
module mac_acc_out_fifo
  import mac_acc_pkg::*;
#(
  parameter int W = 49
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_full
);
  logic [W-1:0] r_mem [FIFO_DEPTH];
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_pop;
  logic         w_push_ok;
  logic         w_wr_ptr;

  assign o_valid   = (r_count != 2'd0);
  assign o_full    = (r_count == 2'(FIFO_DEPTH));
  assign o_data    = r_mem[r_rd_ptr];
  assign w_pop     = o_valid && i_pop_ready;
  assign w_push_ok = i_push && (!o_full || w_pop);
  // When full and popping, the write lands in the slot being vacated
  assign w_wr_ptr  = r_rd_ptr ^ r_count[0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push_ok) r_mem[w_wr_ptr] <= i_data;
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + 2'(w_push_ok) - 2'(w_pop);
    end
  end
endmodule

// File: rtl/mac_result_accumulator.sv
// Sums frames of MAC results and hands each frame sum out through a 2-entry buffer.
// Define MAC_ACC_SATURATE_EN for saturating accumulation with a per-frame out_sat flag.
module mac_result_accumulator
  import mac_acc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 48,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 clear,
  input  logic [CNT_WIDTH-1:0] frame_len,
  mac_result_accumulator_if.slave bus,
  output logic                 busy,
  output logic                 drop_err
);
`ifdef MAC_ACC_SATURATE_EN
  localparam int ENTRY_W = ACC_WIDTH + 1;
`else
  localparam int ENTRY_W = ACC_WIDTH;
`endif

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_len;
  acc_t                 r_acc;
  logic                 w_first;
  logic                 w_done;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_fifo_valid;
  logic [CNT_WIDTH-1:0] w_len;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  acc_t                 w_sample;
  acc_t                 w_base;
  acc_t                 w_acc_next;
  logic [ENTRY_W-1:0]   w_push_data;
  logic [ENTRY_W-1:0]   w_head;

  // A sample seen while IDLE starts a new frame and latches its length
  assign w_first    = (r_state == IDLE);
  assign w_len      = w_first ? ((frame_len == '0) ? CNT_WIDTH'(1) : frame_len) : r_len;
  assign w_cnt_next = w_first ? CNT_WIDTH'(1) : r_cnt + CNT_WIDTH'(1);
  assign w_sample   = acc_t'(bus.in_data);
  assign w_base     = w_first ? '0 : r_acc;
  assign w_done     = bus.in_valid && (w_cnt_next == w_len);
  assign w_push     = w_done && !clear;
  assign w_pop      = w_fifo_valid && bus.out_ready;
  assign busy       = (r_state == ACCUM);
  assign bus.out_valid = w_fifo_valid;

`ifdef MAC_ACC_SATURATE_EN
  acc_entry_t w_step;
  logic       w_sat_next;
  logic       r_sat;

  assign w_step      = sat_add(w_base, w_sample, ACC_WIDTH);
  assign w_acc_next  = w_step.sum;
  assign w_sat_next  = w_step.sat | (!w_first && r_sat);
  assign w_push_data = {ACC_WIDTH'(w_acc_next), w_sat_next};
  assign bus.out_sum = w_head[ENTRY_W-1:1];
  assign bus.out_sat = w_head[0];
`else
  assign w_acc_next  = wrap_add(w_base, w_sample, ACC_WIDTH);
  assign w_push_data = ACC_WIDTH'(w_acc_next);
  assign bus.out_sum = w_head;
  assign bus.out_sat = 1'b0;
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_len    <= '0;
      r_acc    <= '0;
      drop_err <= 1'b0;
`ifdef MAC_ACC_SATURATE_EN
      r_sat    <= 1'b0;
`endif
    end else if (clear) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      drop_err <= 1'b0;
`ifdef MAC_ACC_SATURATE_EN
      r_sat    <= 1'b0;
`endif
    end else begin
      if (bus.in_valid) begin
        r_acc   <= w_acc_next;
        r_cnt   <= w_cnt_next;
        r_len   <= w_len;
        r_state <= w_done ? IDLE : ACCUM;
`ifdef MAC_ACC_SATURATE_EN
        r_sat   <= w_sat_next;
`endif
      end
      // The MAC cannot be stalled, so a frame with nowhere to go is lost and flagged
      if (w_push && w_full && !w_pop) drop_err <= 1'b1;
    end
  end

  mac_acc_out_fifo #(.W(ENTRY_W)) u_fifo (
    .i_clk      (ap_clk),
    .i_rst_n    (ap_rst_n),
    .i_flush    (clear),
    .i_push     (w_push),
    .i_data     (w_push_data),
    .i_pop_ready(bus.out_ready),
    .o_valid    (w_fifo_valid),
    .o_data     (w_head),
    .o_full     (w_full)
  );
endmodule

// File: tb/tb_mac_result_accumulator.sv
// Bench for mac_result_accumulator: queue-based frame model plus directed literal checks.
module tb_mac_result_accumulator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] frame_len = 16'd4;
  logic        busy, drop_err, busy32, drop32;
  bit          en32 = 1'b0;
  bit          chk_en = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;

  mac_result_accumulator_if #(.DATA_WIDTH(32), .ACC_WIDTH(48)) bus ();
  mac_result_accumulator_if #(.DATA_WIDTH(32), .ACC_WIDTH(32)) b32 ();

  assign b32.in_valid  = bus.in_valid & en32;
  assign b32.in_data   = bus.in_data;
  assign b32.out_ready = 1'b1;

  mac_result_accumulator #(.DATA_WIDTH(32), .ACC_WIDTH(48), .CNT_WIDTH(16)) dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .clear(clear), .frame_len(frame_len),
    .bus(bus), .busy(busy), .drop_err(drop_err));

  mac_result_accumulator #(.DATA_WIDTH(32), .ACC_WIDTH(32), .CNT_WIDTH(16)) dut32 (
    .ap_clk(clk), .ap_rst_n(rst_n), .clear(clear), .frame_len(frame_len),
    .bus(b32), .busy(busy32), .drop_err(drop32));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frames summed as plain integers, completed sums kept in a 2-deep queue
  typedef struct {
    longint sum;
    bit     sat;
  } ent_t;

  localparam longint MAXP = (longint'(1) <<< 47) - 1;
  localparam longint MINN = -MAXP - 1;

  ent_t   q[$];
  bit     m_busy, m_drop, m_sat;
  longint m_sum;
  int     m_L, m_cnt;

  function automatic longint fit48(input longint r, inout bit s);
`ifdef MAC_ACC_SATURATE_EN
    if (r > MAXP) begin s = 1'b1; return MAXP; end
    if (r < MINN) begin s = 1'b1; return MINN; end
    return r;
`else
    return (r <<< 16) >>> 16;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit     push, pop;
    longint d;
    if (!rst_n) begin
      q.delete();
      m_busy = 0; m_drop = 0; m_cnt = 0; m_sum = 0; m_sat = 0;
    end else if (clear) begin
      q.delete();
      m_busy = 0; m_drop = 0; m_cnt = 0;
    end else begin
      pop  = (q.size() > 0) && bus.out_ready;
      push = 1'b0;
      if (bus.in_valid) begin
        d = bus.in_data;
        if (!m_busy) begin
          m_L   = (frame_len == 16'd0) ? 1 : int'(frame_len);
          m_sum = d;
          m_sat = 1'b0;
          m_cnt = 1;
        end else begin
          m_sum = fit48(m_sum + d, m_sat);
          m_cnt++;
        end
        if (m_cnt == m_L) begin push = 1'b1; m_busy = 1'b0; end
        else m_busy = 1'b1;
      end
      if (pop) void'(q.pop_front());
      if (push) begin
        if (q.size() < 2) q.push_back('{m_sum, m_sat});
        else m_drop = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", bus.out_valid, 64'(q.size() > 0));
      check("busy", busy, m_busy);
      check("drop_err", drop_err, m_drop);
      if (q.size() > 0) begin
        check("out_sum", bus.out_sum, q[0].sum);
        check("out_sat", bus.out_sat, q[0].sat);
      end
    end
  end

  task automatic drive(input bit v, input logic [31:0] d);
    bus.in_valid = v;
    bus.in_data  = d;
    @(negedge clk);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_sum", bus.out_sum, 0);
    check("rst_busy", busy, 0);
    check("rst_drop_err", drop_err, 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Four-sample frame
    frame_len = 16'd4;
    drive(1, 1); drive(1, 2); drive(1, 3);
    check("t1_busy", busy, 1);
    drive(1, 4);
    check("t1_valid", bus.out_valid, 1);
    check("t1_sum", bus.out_sum, 10);
    drive(0, 0);
    check("t1_popped", bus.out_valid, 0);

    // Zero length means one-sample frames, sign-extended
    frame_len = 16'd0;
    drive(1, -5);
    check("t2_sum_a", bus.out_sum, -5);
    check("t2_busy", busy, 0);
    drive(1, 7);
    check("t2_sum_b", bus.out_sum, 7);
    drive(0, 0);

    // Third frame into a full buffer is dropped
    frame_len = 16'd1;
    bus.out_ready = 1'b0;
    drive(1, 11); drive(1, 22); drive(1, 33);
    check("t3_drop", drop_err, 1);
    check("t3_head", bus.out_sum, 11);
    bus.out_ready = 1'b1;
    drive(0, 0);
    check("t3_second", bus.out_sum, 22);
    drive(0, 0);
    check("t3_empty", bus.out_valid, 0);

    // Clear aborts a partial frame even with a sample present
    frame_len = 16'd3;
    drive(1, 100); drive(1, 200);
    check("t4_busy", busy, 1);
    clear = 1'b1;
    drive(1, 300);
    clear = 1'b0;
    check("t4_busy_clr", busy, 0);
    check("t4_valid_clr", bus.out_valid, 0);
    check("t4_drop_clr", drop_err, 0);
    drive(1, 1); drive(1, 2); drive(1, 3);
    check("t4_sum", bus.out_sum, 6);
    drive(0, 0);

    // Push into a full buffer while popping keeps everything
    frame_len = 16'd1;
    bus.out_ready = 1'b0;
    drive(1, 5); drive(1, 6);
    bus.out_ready = 1'b1;
    drive(1, 7);
    check("tf_drop", drop_err, 0);
    check("tf_head", bus.out_sum, 6);
    drive(0, 0);
    check("tf_next", bus.out_sum, 7);
    drive(0, 0);

    // Large positive samples: fits in 48 bits, overflows 32 bits
    frame_len = 16'd2;
    en32 = 1'b1;
    drive(1, 32'h7FFF_FFFF); drive(1, 32'h7FFF_FFFF);
    en32 = 1'b0;
    check("t5_sum48", bus.out_sum, 64'h0000_0000_FFFF_FFFE);
    check("t5_sat48", bus.out_sat, 0);
    check("t5_valid32", b32.out_valid, 1);
`ifdef MAC_ACC_SATURATE_EN
    check("t5_sum32", b32.out_sum, 64'h0000_0000_7FFF_FFFF);
    check("t5_sat32", b32.out_sat, 1);
`else
    check("t5_sum32", b32.out_sum, -2);
    check("t5_sat32", b32.out_sat, 0);
`endif
    check("t5_busy32", busy32, 0);
    check("t5_drop32", drop32, 0);
    drive(0, 0);

    // Asynchronous reset mid-frame with a frame waiting
    frame_len = 16'd1;
    bus.out_ready = 1'b0;
    drive(1, 9);
    frame_len = 16'd5;
    drive(1, 1); drive(1, 2);
    check("t6_pre_busy", busy, 1);
    check("t6_pre_valid", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_valid", bus.out_valid, 0);
    check("t6_sum", bus.out_sum, 0);
    check("t6_drop", drop_err, 0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    frame_len = 16'd2;
    drive(1, 3); drive(1, 4);
    check("t6_after", bus.out_sum, 7);
    drive(0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      bus.out_ready = ($urandom_range(0, 9) < 7);
      clear = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 19) == 0) frame_len = 16'($urandom_range(0, 5));
      drive(1'($urandom_range(0, 1)), $urandom);
    end
    clear = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) drive(0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
